// File: rtl/memShare_config_pkg.sv
// Shared memShare configuration: sequence-walker state encoding, L1PA page layout
// and default sizing constants.
package memShare_config_pkg;

    localparam int RQST_BITWIDTH_DEF = 8;
    localparam int PAGE_NUM_DEF      = 64;
    localparam int SEQ_SIZE_DEF      = 4;
    localparam int SHIFT_W_DEF       = $clog2(RQST_BITWIDTH_DEF);
    localparam int DELTA_W_DEF       = SHIFT_W_DEF;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        EMIT
    } seqw_state_e;

    // isGtr sits in the LSB so the page reads as {shift, delta, isGtr}
    typedef struct packed {
        logic [SHIFT_W_DEF-1:0] shift;
        logic [DELTA_W_DEF-1:0] delta;
        logic                   isGtr;
    } l1pa_page_t;

endpackage

// File: rtl/memshare_seq_regfile.sv
// Host-writable shift-pattern store: one write port, one registered read port.
// The read register only loads on rdEn, so a captured page holds until the next read.
module memshare_seq_regfile
    import memShare_config_pkg::*;
#(
    parameter int PAGE_NUM = PAGE_NUM_DEF,
    parameter int ADDR_W   = $clog2(PAGE_NUM),
    parameter int PAGE_W   = SHIFT_W_DEF + DELTA_W_DEF + 1
) (
    input  logic              sys_clk,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [PAGE_W-1:0] wrData,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [PAGE_W-1:0] rdData_p1
);

    logic [PAGE_W-1:0] mem [PAGE_NUM];

    // Same-edge read of a location being written returns the old contents
    always_ff @(posedge sys_clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
        if (rdEn) begin
            rdData_p1 <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/memshare_seq_walker.sv
// memShare control path: walks a stored L1PA shift-pattern sequence per request,
// emitting one accumulated shift beat per page under valid/ready backpressure.
module memshare_seq_walker
    import memShare_config_pkg::*;
#(
    parameter int RQST_BITWIDTH = RQST_BITWIDTH_DEF,
    parameter int PAGE_NUM      = PAGE_NUM_DEF,
    parameter int ADDR_W        = $clog2(PAGE_NUM),
    parameter int SHIFT_W       = $clog2(RQST_BITWIDTH),
    parameter int DELTA_W       = SHIFT_W,
    parameter int SEQ_SIZE      = SEQ_SIZE_DEF,
    parameter int PAGE_W        = SHIFT_W + DELTA_W + 1,
    localparam int IDX_W        = (SEQ_SIZE > 1) ? $clog2(SEQ_SIZE) : 1
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic [RQST_BITWIDTH-1:0] rqst_flag_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [SHIFT_W-1:0]       l1pa_shift_o,
    output logic [IDX_W-1:0]         seq_idx_o,
    output logic                     last_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     seq_ovf_o,
    input  logic [ADDR_W-1:0]        regType0_waddr_i,
    input  logic [PAGE_W-1:0]        regType0_wdata_i,
    input  logic                     regType0_we_i
);

    function automatic logic [SHIFT_W-1:0] wrapAdd(input logic [SHIFT_W-1:0] a,
                                                   input logic [SHIFT_W-1:0] b);
        return a + b;
    endfunction

    function automatic logic [ADDR_W-1:0] wrapAddr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(PAGE_NUM - 1)) ? '0 : a + 1'b1;
    endfunction

    seqw_state_e       state, stateNext;
    logic [SHIFT_W-1:0] acc, accNext;
    logic [IDX_W-1:0]   cnt, cntNext;
    logic [ADDR_W-1:0]  addr, addrNext;
    logic [ADDR_W-1:0]  flagAddr;
    logic [PAGE_W-1:0]  page_p1;
    logic [SHIFT_W-1:0] pageShift;
    logic [SHIFT_W-1:0] pageDelta;
    logic               pageIsGtr;
    logic               cntAtMax;
    logic               isLast;
    logic               emitting;

    generate
        if (RQST_BITWIDTH > ADDR_W) begin : g_flagTrim
            logic unusedFlagBits;
            assign flagAddr       = rqst_flag_i[ADDR_W-1:0];
            assign unusedFlagBits = ^rqst_flag_i[RQST_BITWIDTH-1:ADDR_W];
        end else begin : g_flagExt
            assign flagAddr = ADDR_W'(rqst_flag_i);
        end
    endgenerate

    // ---- RD -> EMIT: page captured once per beat ----
    memshare_seq_regfile #(
        .PAGE_NUM (PAGE_NUM),
        .ADDR_W   (ADDR_W),
        .PAGE_W   (PAGE_W)
    ) u_regfile (
        .sys_clk   (sys_clk),
        .wrEn      (regType0_we_i),
        .wrAddr    (regType0_waddr_i),
        .wrData    (regType0_wdata_i),
        .rdEn      (state == RD),
        .rdAddr    (addr),
        .rdData_p1 (page_p1)
    );

    assign pageShift = page_p1[PAGE_W-1 -: SHIFT_W];
    assign pageDelta = SHIFT_W'(page_p1[DELTA_W:1]);
    assign pageIsGtr = page_p1[0];
    assign cntAtMax  = (cnt == IDX_W'(SEQ_SIZE - 1));
    assign isLast    = !pageIsGtr || cntAtMax;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            addr  <= '0;
        end else begin
            state <= stateNext;
            acc   <= accNext;
            cnt   <= cntNext;
            addr  <= addrNext;
        end
    end

    always_comb begin
        stateNext = state;
        accNext   = acc;
        cntNext   = cnt;
        addrNext  = addr;
        case (state)
            IDLE: begin
                if (in_valid_i) begin
                    addrNext  = flagAddr;
                    cntNext   = '0;
                    accNext   = '0;
                    stateNext = RD;
                end
            end
            RD: stateNext = EMIT;
            EMIT: begin
                if (out_ready_i) begin
                    if (isLast) begin
                        stateNext = IDLE;
                    end else begin
                        accNext   = wrapAdd(acc, pageDelta);
                        cntNext   = cnt + 1'b1;
                        addrNext  = wrapAddr(addr);
                        stateNext = RD;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are forced quiet for as long as rst is held, not just after its edge
    assign emitting     = (state == EMIT) && !rst;
    assign in_ready_o   = (state == IDLE) && !rst;
    assign out_valid_o  = emitting;
    assign l1pa_shift_o = emitting ? wrapAdd(pageShift, acc) : '0;
    assign seq_idx_o    = emitting ? cnt : '0;
    assign last_o       = emitting && isLast;
    assign seq_ovf_o    = emitting && pageIsGtr && cntAtMax;

endmodule

// File: tb/tb_memshare_seq_walker.sv
// Randomised self-checking bench for memshare_seq_walker against a sequence-level
// reference model of the page store and shift accumulation.
module tb_memshare_seq_walker;
    import memShare_config_pkg::*;

    localparam int NPAGE = 64;
    localparam int NSEQ  = 4;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic [7:0] rqst_flag_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic [2:0] l1pa_shift_o;
    logic [1:0] seq_idx_o;
    logic       last_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       seq_ovf_o;
    logic [5:0] regType0_waddr_i;
    logic [6:0] regType0_wdata_i;
    logic       regType0_we_i;

    int checks = 0;
    int errors = 0;

    // reference model state
    int modelShift [NPAGE];
    int modelDelta [NPAGE];
    int modelGtr   [NPAGE];
    int exShift [NSEQ];
    int exLast  [NSEQ];
    int exOvf   [NSEQ];
    int exBeats;

    always #5 sys_clk = ~sys_clk;

    memshare_seq_walker dut (
        .sys_clk          (sys_clk),
        .rst              (rst),
        .rqst_flag_i      (rqst_flag_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .l1pa_shift_o     (l1pa_shift_o),
        .seq_idx_o        (seq_idx_o),
        .last_o           (last_o),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .seq_ovf_o        (seq_ovf_o),
        .regType0_waddr_i (regType0_waddr_i),
        .regType0_wdata_i (regType0_wdata_i),
        .regType0_we_i    (regType0_we_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] packPage(input int sh, input int dl, input int g);
        l1pa_page_t p;
        p.shift = 3'(sh);
        p.delta = 3'(dl);
        p.isGtr = 1'(g);
        return p;
    endfunction

    // Sequence from flag: pages a, a+1, ... (mod 64), shift = page.shift + sum of
    // earlier deltas (mod 8); stops at the first isGtr=0 page or after NSEQ pages.
    task automatic modelSeq(input int flag);
        int a, acc;
        a = flag % NPAGE;
        acc = 0;
        exBeats = 0;
        for (int i = 0; i < NSEQ; i++) begin
            int p;
            p = (a + i) % NPAGE;
            exShift[i] = (modelShift[p] + acc) % 8;
            exLast[i]  = (modelGtr[p] == 0 || i == NSEQ - 1) ? 1 : 0;
            exOvf[i]   = (modelGtr[p] == 1 && i == NSEQ - 1) ? 1 : 0;
            acc = (acc + modelDelta[p]) % 8;
            exBeats++;
            if (exLast[i] == 1) break;
        end
    endtask

    task automatic writePage(input int a, input int sh, input int dl, input int g);
        regType0_we_i    = 1'b1;
        regType0_waddr_i = 6'(a);
        regType0_wdata_i = packPage(sh, dl, g);
        @(posedge sys_clk); #1;
        regType0_we_i = 1'b0;
        modelShift[a] = sh;
        modelDelta[a] = dl;
        modelGtr[a]   = g;
    endtask

    task automatic checkBeat(input int b);
        check("beat_valid", out_valid_o, 1);
        check("beat_shift", l1pa_shift_o, exShift[b]);
        check("beat_idx",   seq_idx_o, b);
        check("beat_last",  last_o, exLast[b]);
        check("beat_ovf",   seq_ovf_o, exOvf[b]);
        check("beat_rdy",   in_ready_o, 0);
    endtask

    // stall < 0 picks a random stall per beat; called and returns at #1 after an edge
    task automatic runSeq(input logic [7:0] flag, input int stall);
        int st;
        modelSeq(flag);
        check("idle_ready", in_ready_o, 1);
        rqst_flag_i = flag;
        in_valid_i  = 1'b1;
        @(posedge sys_clk); #1;
        in_valid_i  = 1'b0;
        rqst_flag_i = 8'($urandom);
        for (int b = 0; b < exBeats; b++) begin
            check("rd_valid", out_valid_o, 0);
            check("rd_ready", in_ready_o, 0);
            @(posedge sys_clk); #1;
            st = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            for (int s = 0; s <= st; s++) begin
                checkBeat(b);
                out_ready_i = (s == st);
                @(posedge sys_clk); #1;
            end
            out_ready_i = 1'b0;
        end
        check("end_ready", in_ready_o, 1);
        check("end_valid", out_valid_o, 0);
    endtask

    initial begin
        rst = 1'b1;
        rqst_flag_i = '0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        regType0_we_i = 1'b0;
        regType0_waddr_i = '0;
        regType0_wdata_i = '0;
        for (int i = 0; i < NPAGE; i++) begin
            modelShift[i] = 0;
            modelDelta[i] = 0;
            modelGtr[i]   = 0;
        end
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_ready", in_ready_o, 0);
        check("rst_valid", out_valid_o, 0);
        check("rst_shift", l1pa_shift_o, 0);
        check("rst_idx",   seq_idx_o, 0);
        check("rst_last",  last_o, 0);
        check("rst_ovf",   seq_ovf_o, 0);
        // page store is unknown until written, so give every page a defined value
        for (int i = 0; i < NPAGE; i++) writePage(i, 0, 0, 0);
        rst = 1'b0;
        #0;
        check("post_rst_ready", in_ready_o, 1);

        // basic two-beat sequence: 3 then 6
        writePage(5, 3, 2, 1);
        writePage(6, 4, 0, 0);
        runSeq(8'h05, 0);

        // backpressure: three stalled cycles on every beat
        runSeq(8'h05, 3);

        // sequence-length guard: four chained pages, truncated with overflow
        for (int i = 10; i < 14; i++) writePage(i, $urandom_range(0, 7), 1, 1);
        runSeq(8'h0A, 0);

        // address wrap 63 -> 0 and modular shift (4+5) mod 8 = 1
        writePage(63, 6, 5, 1);
        writePage(0, 4, 0, 0);
        runSeq(8'h3F, 0);

        // reset in the middle of a beat
        in_valid_i = 1'b1;
        rqst_flag_i = 8'h05;
        @(posedge sys_clk); #1;
        in_valid_i = 1'b0;
        @(posedge sys_clk); #1;
        check("pre_abort_valid", out_valid_o, 1);
        rst = 1'b1;
        #1;
        check("abort_rst_valid", out_valid_o, 0);
        check("abort_rst_ready", in_ready_o, 0);
        @(posedge sys_clk); #1;
        rst = 1'b0;
        #1;
        check("abort_valid", out_valid_o, 0);
        check("abort_ovf",   seq_ovf_o, 0);
        check("abort_ready", in_ready_o, 1);
        runSeq(8'h05, 0);

        // write lands on the RD edge that reads the same page: old data wins
        in_valid_i = 1'b1;
        rqst_flag_i = 8'h05;
        @(posedge sys_clk); #1;
        in_valid_i = 1'b0;
        regType0_we_i = 1'b1;
        regType0_waddr_i = 6'd5;
        regType0_wdata_i = packPage(7, 0, 0);
        @(posedge sys_clk); #1;
        // a write during EMIT must not disturb the captured page either
        regType0_wdata_i = packPage(1, 1, 1);
        check("coll_shift", l1pa_shift_o, 3);
        check("coll_last",  last_o, 0);
        @(posedge sys_clk); #1;
        regType0_we_i = 1'b0;
        check("hold_shift", l1pa_shift_o, 3);
        check("hold_last",  last_o, 0);
        out_ready_i = 1'b1;
        @(posedge sys_clk); #1;
        out_ready_i = 1'b0;
        @(posedge sys_clk); #1;
        check("coll_b1_shift", l1pa_shift_o, 6);
        check("coll_b1_last",  last_o, 1);
        out_ready_i = 1'b1;
        @(posedge sys_clk); #1;
        out_ready_i = 1'b0;
        writePage(5, 7, 0, 0);
        runSeq(8'h05, 0);
        check("new_page_shift", exShift[0], 7);

        // randomised pages, flags (upper bits ignored) and stalls
        for (int n = 0; n < 20; n++) begin
            for (int w = 0; w < 4; w++)
                writePage($urandom_range(0, NPAGE - 1), $urandom_range(0, 7),
                          $urandom_range(0, 7), $urandom_range(0, 1));
            runSeq(8'($urandom), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memshare_seq_walker.md
Name: memshare_seq_walker

Overview:
- Parametrised successor to the memShare control path.
- Accepts one request flag per transaction over a valid/ready handshake.
- Walks a variable-length L1PA shift-pattern sequence stored in an internal host-writable register file, emitting one shift beat per pattern with output backpressure.
- Adds per-beat delta accumulation, a sequence-length guard and address wrap-around.
- Sits between the access-request generator and the L1PA.

Parameters:
- RQST_BITWIDTH, 8, width of the request flag.
- PAGE_NUM, 64, number of register-file pages.
- ADDR_W, $clog2(PAGE_NUM), register-file address width.
- SHIFT_W, $clog2(RQST_BITWIDTH), L1PA shift width.
- DELTA_W, SHIFT_W, shift-delta field width.
- SEQ_SIZE, 4, maximum patterns per sequence.
- PAGE_W, SHIFT_W+DELTA_W+1, page width; page layout is {shift, delta, isGtr}, with isGtr in the LSB.

Ports:
- sys_clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- rqst_flag_i, in, RQST_BITWIDTH, request flag.
- in_valid_i, in, 1, request valid.
- in_ready_o, out, 1, block idle and able to accept a request.
- l1pa_shift_o, out, SHIFT_W, shift control to the L1PA.
- seq_idx_o, out, $clog2(SEQ_SIZE), index of the current pattern.
- last_o, out, 1, current beat is the final beat of the sequence.
- out_valid_i… no: out_valid_o, out, 1, shift beat valid.
- out_ready_i, in, 1, L1PA accepts the beat.
- seq_ovf_o, out, 1, sequence truncated at SEQ_SIZE.
- regType0_waddr_i, in, ADDR_W, write address.
- regType0_wdata_i, in, PAGE_W, write data.
- regType0_we_i, in, 1, write enable.

Behaviour:
- Single clock domain, sys_clk. rst is synchronous and active-high.
- While rst is high:
  - state goes to IDLE; acc, cnt and addr clear to 0.
  - in_ready_o, out_valid_o, last_o and seq_ovf_o are 0; l1pa_shift_o and seq_idx_o are 0.
  - Register-file contents are not reset and survive rst.
- FSM states: IDLE, RD, EMIT.
  - IDLE: in_ready_o=1. On in_valid_i & in_ready_o: addr <= rqst_flag_i[ADDR_W-1:0], cnt <= 0, acc <= 0, go to RD.
  - RD: the synchronous register-file read of addr is in flight. Always go to EMIT on the next cycle.
  - EMIT: out_valid_o=1.
    - l1pa_shift_o = (page.shift + acc) mod 2^SHIFT_W.
    - seq_idx_o = cnt.
    - last_o = !page.isGtr | (cnt == SEQ_SIZE-1).
    - seq_ovf_o = page.isGtr & (cnt == SEQ_SIZE-1).
    - All outputs hold stable while out_ready_i=0.
    - On out_ready_i with last_o=1: go to IDLE.
    - On out_ready_i with last_o=0: acc <= (acc + page.delta) mod 2^SHIFT_W, cnt <= cnt+1, addr <= (addr+1) mod PAGE_NUM, go to RD.
- Latency: request accepted in cycle T gives the first beat valid in T+2. Each subsequent beat is valid 2 cycles after the previous handshake.
- in_ready_o is low in RD and EMIT; a new request is never accepted mid-sequence.
- The page read for EMIT is captured once in RD and held in a register, so a write during EMIT does not alter the presented beat.
- Register file:
  - Synchronous write when regType0_we_i=1; the write port is independent of the FSM.
  - Synchronous read with 1-cycle latency.
  - Simultaneous write and read of the same address returns the old data (read-first).
- A reset asserted mid-sequence aborts the sequence. No partial beat is emitted after rst is released.

Decomposition:
- Add to memShare_config_pkg:
  - enum seqw_state_e {IDLE, RD, EMIT}.
  - packed struct l1pa_page_t {shift, delta, isGtr}.
  - Default constants for SEQ_SIZE and PAGE_NUM.
- One sub-module, memshare_seq_regfile: PAGE_NUM x PAGE_W distributed RAM, 1 write port, 1 read port, read-first.
- FSM, accumulator and handshake logic stay in the top module.

Test Plan:
1. Basic two-beat sequence:
   - Write page5={3,2,1} and page6={4,0,0}, then send flag 8'h05 with out_ready_i=1.
   - Beat0: shift=3, idx0, last0, valid at T+2.
   - Beat1: shift=6, idx1, last1, valid at T+4.
   - Then in_ready_o=1.
2. Backpressure:
   - Same as scenario 1, with out_ready_i=0 for 3 cycles during beat0.
   - shift=3, idx0 and out_valid_o stay stable, with no advance.
   - Beat1 follows 2 cycles after out_ready_i rises.
3. Overflow guard:
   - Pages 10..13 all with isGtr=1 and delta=1; SEQ_SIZE=4.
   - Exactly 4 beats are emitted, each with shift = page.shift + idx.
   - On beat3: last_o=1 and seq_ovf_o=1. Return to IDLE.
4. Address wrap and modular shift:
   - page63={6,5,1}, page0={4,0,0}, flag 8'h3F.
   - Beats: 6, then (4+5) mod 8 = 1 with last_o=1.
5. Reset mid-EMIT:
   - Assert rst for 1 cycle while out_valid_o=1.
   - Next cycle: out_valid_o=0, seq_ovf_o=0. After release: in_ready_o=1.
   - A re-request of 8'h05 reproduces scenario 1 exactly, confirming the register file is intact.
6. Write/read collision:
   - Write page5={7,0,0} in the RD cycle that reads page5, which previously held {3,2,1}.
   - The beat shows shift=3 (old data). The next request of 8'h05 shows shift=7, last1.
